// File: rtl/risc_datapath.sv
// risc_datapath: VeriRisc PC/IR/AC/ALU datapath with phase sequencer, halt latch and external memory port
module risc_datapath (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel,
  input  logic       rd,
  input  logic       ld_ir,
  input  logic       inc_pc,
  input  logic       halt,
  input  logic       ld_pc,
  input  logic       data_e,
  input  logic       ld_ac,
  input  logic       wr,
  output logic [2:0] opcode,
  output logic [2:0] phase,
  output logic       zero,
  output logic       halted,
  output logic [4:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       mem_re,
  output logic       mem_we
);
  logic [4:0] pc;
  logic [7:0] ir, ac, bus, alu;
  assign bus = rd ? mem_rdata : data_e ? ac : 8'h00;
  assign opcode = ir[7:5];
  assign zero = ac == 8'h00;
  assign mem_addr = sel ? pc : ir[4:0];
  assign mem_wdata = ac;
  assign mem_re = rd;
  assign mem_we = wr & ~halted;
  always_comb
    alu = opcode == 3'd2 ? ac + bus : opcode == 3'd3 ? ac & bus : opcode == 3'd4 ? ac ^ bus : bus;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= 5'd0;
      ir <= 8'h00;
      ac <= 8'h00;
      phase <= 3'd0;
      halted <= 1'b0;
    end else if (!halted) begin
      phase <= phase + 3'd1;
      halted <= halt;
      if (ld_ir) ir <= bus;
      if (ld_pc) pc <= ir[4:0];
      else if (inc_pc) pc <= pc + 5'd1;
      if (ld_ac) ac <= alu;
    end
endmodule
